// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//
// Program-counter and fetch stage of the MIPS pipeline. Drives the current PC
// as a byte address into an asynchronous-read instruction memory and captures
// the returned word into the IF/ID pipeline register. Handles decode stalls,
// branch/jump redirects and a halt on the HALT_WORD encoding (MIPS `break`).
//
// Parameters:
//   RESET_PC    PC loaded on reset (bits [1:0] must be 0)
//   HALT_WORD   instruction encoding that stops fetch
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   stall        in   hold PC and IF/ID
//   redirect     in   taken branch/jump; overrides stall and exits HALTED
//   redirect_pc  in   redirect target, bits [1:0] ignored
//   imem_addr    out  byte address to instruction memory (== pc)
//   imem_instr   in   instruction word from memory (combinational read)
//   pc           out  current fetch PC
//   if_id_instr  out  latched instruction for decode
//   if_id_pc4    out  PC+4 of the latched instruction
//   if_id_valid  out  IF/ID holds a real instruction (0 = bubble)
//   halted       out  fetch is in the HALTED state
//   fetch_count  out  number of instructions latched with valid=1
// ---------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'h0000_000D
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic {
    FETCH,
    HALTED
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] count_q, count_d;

  logic [31:0] pc_plus4;
  logic        is_halt_word;

  assign pc_plus4     = pc_q + 32'd4;  // wraps FFFF_FFFC -> 0
  assign is_halt_word = (imem_instr == HALT_WORD);

  // Priority: redirect > halted > stall > normal capture.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    count_d = count_q;

    if (redirect) begin
      // Masking instead of slicing keeps every redirect_pc bit in use.
      pc_d    = redirect_pc & 32'hFFFF_FFFC;
      instr_d = '0;
      valid_d = 1'b0;
      state_d = FETCH;
    end else if (state_q == HALTED) begin
      instr_d = '0;
      valid_d = 1'b0;
    end else if (!stall) begin
      instr_d = imem_instr;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
      count_d = count_q + 32'd1;
      if (is_halt_word) begin
        state_d = HALTED;
      end else begin
        pc_d = pc_plus4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;
  assign halted      = (state_q == HALTED);
  assign fetch_count = count_q;

endmodule
